// File: rtl/leak_monitor_pkg.sv
`default_nettype none
// ------------------------------------------------------------------------
// leak_monitor_pkg : shared state encoding, saturation constants, helpers
// Rev 1.0
// ------------------------------------------------------------------------
package leak_monitor_pkg;

   localparam int unsigned CNT_WIDTH_DEF   = 8;
   localparam int unsigned TRIAL_WIDTH_DEF = 16;

   localparam logic [CNT_WIDTH_DEF-1:0]   CNT_SAT   = '1;
   localparam logic [TRIAL_WIDTH_DEF-1:0] TRIAL_SAT = '1;

   localparam logic [1:0] C_IDLE   = 2'd0;
   localparam logic [1:0] C_RUN    = 2'd1;
   localparam logic [1:0] C_REPORT = 2'd2;

   typedef enum logic [1:0] {
      IDLE   = C_IDLE,
      RUN    = C_RUN,
      REPORT = C_REPORT
   } state_e;

   // Increment that sticks at the all-ones value of a 'width'-bit counter.
   function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
      logic [31:0] w_max;
      w_max = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      return (value >= w_max) ? w_max : (value + 32'd1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/leak_monitor_if.sv
`default_nettype none
// ------------------------------------------------------------------------
// leak_monitor_if : trial handshake inputs and verdict/statistics outputs
// Rev 1.0
// ------------------------------------------------------------------------
interface leak_monitor_if
   import leak_monitor_pkg::*;
#(
   parameter int unsigned CNT_WIDTH   = CNT_WIDTH_DEF,
   parameter int unsigned TRIAL_WIDTH = TRIAL_WIDTH_DEF
);
   logic                   start;
   logic                   done_one;
   logic                   done_two;
   logic                   busy;
   logic [CNT_WIDTH-1:0]   latency_one;
   logic [CNT_WIDTH-1:0]   latency_two;
   logic [CNT_WIDTH-1:0]   skew;
   logic                   trial_valid;
   logic                   trial_leak;
   logic                   trial_timeout;
   logic                   leak_sticky;
   logic [TRIAL_WIDTH-1:0] trial_count;
   logic [TRIAL_WIDTH-1:0] leak_count;
   logic [CNT_WIDTH-1:0]   max_skew;

   modport master (
      output start, done_one, done_two,
      input  busy, latency_one, latency_two, skew, trial_valid, trial_leak,
             trial_timeout, leak_sticky, trial_count, leak_count, max_skew
   );

   modport slave (
      input  start, done_one, done_two,
      output busy, latency_one, latency_two, skew, trial_valid, trial_leak,
             trial_timeout, leak_sticky, trial_count, leak_count, max_skew
   );
endinterface
`default_nettype wire

// File: rtl/leak_done_capture.sv
`default_nettype none
// ------------------------------------------------------------------------
// leak_done_capture : first-done latency capture for one multiplier copy
// Rev 1.0
// ------------------------------------------------------------------------
module leak_done_capture #(
   parameter int unsigned CNT_WIDTH = 8,
   parameter int unsigned TIMEOUT   = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_clear,
   input  logic                 i_enable,
   input  logic                 i_done,
   input  logic [CNT_WIDTH-1:0] i_cnt,
   output logic                 o_captured,
   output logic [CNT_WIDTH-1:0] o_latency
);
   localparam logic [CNT_WIDTH-1:0] c_timeout = CNT_WIDTH'(TIMEOUT);

   logic                 r_captured;
   logic [CNT_WIDTH-1:0] r_latency;
   logic                 w_captured_nxt;
   logic [CNT_WIDTH-1:0] w_latency_nxt;

   // Outputs show the post-edge view so the parent can report in the same edge.
   always_comb begin
      w_captured_nxt = r_captured;
      w_latency_nxt  = r_latency;
      if (i_clear) begin
         w_captured_nxt = 1'b0;
         w_latency_nxt  = '0;
      end else if (i_enable && !r_captured) begin
         if (i_done) begin
            w_captured_nxt = 1'b1;
            w_latency_nxt  = i_cnt;
         end else if (i_cnt == c_timeout) begin
            w_latency_nxt  = '1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_captured <= 1'b0;
         r_latency  <= '0;
      end else begin
         r_captured <= w_captured_nxt;
         r_latency  <= w_latency_nxt;
      end
   end

   assign o_captured = w_captured_nxt;
   assign o_latency  = w_latency_nxt;

endmodule
`default_nettype wire

// File: rtl/leak_monitor.sv
`default_nettype none
// ------------------------------------------------------------------------
// leak_monitor : two-copy completion latency, skew and leak statistics
// Rev 1.0
// ------------------------------------------------------------------------
module leak_monitor
   import leak_monitor_pkg::*;
#(
   parameter int unsigned CNT_WIDTH   = CNT_WIDTH_DEF,
   parameter int unsigned TIMEOUT     = 64,
   parameter int unsigned TRIAL_WIDTH = TRIAL_WIDTH_DEF
) (
   input  logic           clk,
   input  logic           rst,
   leak_monitor_if.slave  if_mon
);
   localparam logic [CNT_WIDTH-1:0] c_timeout = CNT_WIDTH'(TIMEOUT);

   state_e                 r_state;
   logic [CNT_WIDTH-1:0]   r_cnt;
   logic                   r_busy;
   logic [CNT_WIDTH-1:0]   r_latency_one;
   logic [CNT_WIDTH-1:0]   r_latency_two;
   logic [CNT_WIDTH-1:0]   r_skew;
   logic                   r_trial_valid;
   logic                   r_trial_leak;
   logic                   r_trial_timeout;
   logic                   r_leak_sticky;
   logic [TRIAL_WIDTH-1:0] r_trial_count;
   logic [TRIAL_WIDTH-1:0] r_leak_count;
   logic [CNT_WIDTH-1:0]   r_max_skew;

   logic                   w_clear;
   logic                   w_run;
   logic                   w_cap_one;
   logic                   w_cap_two;
   logic [CNT_WIDTH-1:0]   w_lat_one;
   logic [CNT_WIDTH-1:0]   w_lat_two;
   logic                   w_both;
   logic                   w_timeout;
   logic                   w_finish;
   logic [CNT_WIDTH-1:0]   w_skew;
   logic                   w_leak;

   assign w_clear = (r_state == IDLE) && if_mon.start;
   assign w_run   = (r_state == RUN);

   leak_done_capture #(.CNT_WIDTH(CNT_WIDTH), .TIMEOUT(TIMEOUT)) u_cap_one (
      .clk        (clk),
      .rst        (rst),
      .i_clear    (w_clear),
      .i_enable   (w_run),
      .i_done     (if_mon.done_one),
      .i_cnt      (r_cnt),
      .o_captured (w_cap_one),
      .o_latency  (w_lat_one)
   );

   leak_done_capture #(.CNT_WIDTH(CNT_WIDTH), .TIMEOUT(TIMEOUT)) u_cap_two (
      .clk        (clk),
      .rst        (rst),
      .i_clear    (w_clear),
      .i_enable   (w_run),
      .i_done     (if_mon.done_two),
      .i_cnt      (r_cnt),
      .o_captured (w_cap_two),
      .o_latency  (w_lat_two)
   );

   // Verdicts use this edge's captures, so a same-edge finish reports at once.
   assign w_both    = w_cap_one && w_cap_two;
   assign w_timeout = !w_both && (r_cnt == c_timeout);
   assign w_finish  = w_run && (w_both || (r_cnt == c_timeout));
   assign w_skew    = (w_lat_one >= w_lat_two) ? (w_lat_one - w_lat_two)
                                               : (w_lat_two - w_lat_one);
   assign w_leak    = (w_lat_one != w_lat_two) || w_timeout;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state         <= IDLE;
         r_cnt           <= '0;
         r_busy          <= 1'b0;
         r_latency_one   <= '0;
         r_latency_two   <= '0;
         r_skew          <= '0;
         r_trial_valid   <= 1'b0;
         r_trial_leak    <= 1'b0;
         r_trial_timeout <= 1'b0;
         r_leak_sticky   <= 1'b0;
         r_trial_count   <= '0;
         r_leak_count    <= '0;
         r_max_skew      <= '0;
      end else begin
         r_trial_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (if_mon.start) begin
                  r_state <= RUN;
                  r_busy  <= 1'b1;
                  r_cnt   <= CNT_WIDTH'(1);
               end
            end
            RUN: begin
               r_cnt <= CNT_WIDTH'(sat_inc(32'(r_cnt), CNT_WIDTH));
               if (w_finish) begin
                  r_state         <= REPORT;
                  r_trial_valid   <= 1'b1;
                  r_latency_one   <= w_lat_one;
                  r_latency_two   <= w_lat_two;
                  r_skew          <= w_skew;
                  r_trial_leak    <= w_leak;
                  r_trial_timeout <= w_timeout;
                  r_trial_count   <= TRIAL_WIDTH'(sat_inc(32'(r_trial_count), TRIAL_WIDTH));
                  if (w_leak) begin
                     r_leak_count  <= TRIAL_WIDTH'(sat_inc(32'(r_leak_count), TRIAL_WIDTH));
                     r_leak_sticky <= 1'b1;
                  end
                  // An abandoned trial's skew is against a forced saturation value, not a real latency.
                  if (!w_timeout && (w_skew > r_max_skew)) begin
                     r_max_skew <= w_skew;
                  end
               end
            end
            REPORT: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign if_mon.busy          = r_busy;
   assign if_mon.latency_one   = r_latency_one;
   assign if_mon.latency_two   = r_latency_two;
   assign if_mon.skew          = r_skew;
   assign if_mon.trial_valid   = r_trial_valid;
   assign if_mon.trial_leak    = r_trial_leak;
   assign if_mon.trial_timeout = r_trial_timeout;
   assign if_mon.leak_sticky   = r_leak_sticky;
   assign if_mon.trial_count   = r_trial_count;
   assign if_mon.leak_count    = r_leak_count;
   assign if_mon.max_skew      = r_max_skew;

endmodule
`default_nettype wire

// File: tb/tb_leak_monitor.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_leak_monitor : directed trials with a scoreboard of expected reports
// Rev 1.0
// ------------------------------------------------------------------------
module tb_leak_monitor;

   localparam int C_TIMEOUT = 64;

   typedef struct {
      int l1;
      int l2;
      int skew;
      bit leak;
      bit to;
      int tc;
      int lc;
      bit sticky;
      int mx;
   } exp_t;

   logic clk;
   logic r_rst;
   logic r_start;
   logic r_d1;
   logic r_d2;

   int   n_err = 0;
   int   n_chk = 0;
   exp_t q[$];
   exp_t m_e;
   int   m_tc = 0;
   int   m_lc = 0;
   bit   m_sticky = 1'b0;
   int   m_mx = 0;

   leak_monitor_if #(.CNT_WIDTH(8), .TRIAL_WIDTH(16)) bus_a ();
   leak_monitor_if #(.CNT_WIDTH(8), .TRIAL_WIDTH(2))  bus_b ();

   assign bus_a.start    = r_start;
   assign bus_a.done_one = r_d1;
   assign bus_a.done_two = r_d2;
   assign bus_b.start    = r_start;
   assign bus_b.done_one = r_d1;
   assign bus_b.done_two = r_d2;

   leak_monitor #(.CNT_WIDTH(8), .TIMEOUT(C_TIMEOUT), .TRIAL_WIDTH(16)) dut_a (
      .clk    (clk),
      .rst    (r_rst),
      .if_mon (bus_a)
   );

   leak_monitor #(.CNT_WIDTH(8), .TIMEOUT(C_TIMEOUT), .TRIAL_WIDTH(2)) dut_b (
      .clk    (clk),
      .rst    (r_rst),
      .if_mon (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void push_exp(input int l1, input int l2, input bit to);
      exp_t e;
      e.l1   = l1;
      e.l2   = l2;
      e.skew = (l1 > l2) ? (l1 - l2) : (l2 - l1);
      e.leak = (l1 != l2) || to;
      e.to   = to;
      if (m_tc < 65535) m_tc++;
      if (e.leak && m_lc < 65535) m_lc++;
      m_sticky = m_sticky | e.leak;
      if (!to && e.skew > m_mx) m_mx = e.skew;
      e.tc     = m_tc;
      e.lc     = m_lc;
      e.sticky = m_sticky;
      e.mx     = m_mx;
      q.push_back(e);
   endfunction

   // Scoreboard: every report pulse must match the oldest pending expectation.
   always @(negedge clk) begin
      if (r_rst && bus_a.trial_valid) begin
         if (q.size() == 0) begin
            check("spurious_valid", 32'(bus_a.trial_valid), 32'd0);
         end else begin
            m_e = q.pop_front();
            check("latency_one", 32'(bus_a.latency_one), 32'(m_e.l1));
            check("latency_two", 32'(bus_a.latency_two), 32'(m_e.l2));
            check("skew",        32'(bus_a.skew),        32'(m_e.skew));
            check("trial_leak",  32'(bus_a.trial_leak),  32'(m_e.leak));
            check("trial_to",    32'(bus_a.trial_timeout), 32'(m_e.to));
            check("trial_count", 32'(bus_a.trial_count), 32'(m_e.tc));
            check("leak_count",  32'(bus_a.leak_count),  32'(m_e.lc));
            check("leak_sticky", 32'(bus_a.leak_sticky), 32'(m_e.sticky));
            check("max_skew",    32'(bus_a.max_skew),    32'(m_e.mx));
            check("busy_valid",  32'(bus_a.busy),        32'd1);
         end
      end
   end

   // d1/d2: edge after start at which done rises (0 = never); restart_at: extra start edge.
   task automatic do_trial(input int d1, input int d2, input int restart_at, input bit hold);
      int l1;
      int l2;
      int last;
      bit to;
      to   = (d1 == 0) || (d2 == 0) || (d1 > C_TIMEOUT) || (d2 > C_TIMEOUT);
      l1   = (d1 == 0 || d1 > C_TIMEOUT) ? 255 : d1;
      l2   = (d2 == 0 || d2 > C_TIMEOUT) ? 255 : d2;
      last = to ? C_TIMEOUT : ((d1 > d2) ? d1 : d2);
      push_exp(l1, l2, to);
      r_start = 1'b1;
      tick();
      r_start = 1'b0;
      for (int e = 1; e <= last; e++) begin
         r_d1    = (d1 != 0) && (e >= d1);
         r_d2    = (d2 != 0) && (e >= d2);
         r_start = (e == restart_at);
         tick();
      end
      r_start = 1'b0;
      if (!hold) begin
         r_d1 = 1'b0;
         r_d2 = 1'b0;
      end
      check("busy_report", 32'(bus_a.busy), 32'd1);
      tick();
      check("busy_idle",  32'(bus_a.busy),        32'd0);
      check("valid_drop", 32'(bus_a.trial_valid), 32'd0);
      check("hold_lat1",  32'(bus_a.latency_one), 32'(l1));
      check("hold_lat2",  32'(bus_a.latency_two), 32'(l2));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"},   32'(bus_a.busy),          32'd0);
      check({tag, "_lat1"},   32'(bus_a.latency_one),   32'd0);
      check({tag, "_lat2"},   32'(bus_a.latency_two),   32'd0);
      check({tag, "_skew"},   32'(bus_a.skew),          32'd0);
      check({tag, "_valid"},  32'(bus_a.trial_valid),   32'd0);
      check({tag, "_leak"},   32'(bus_a.trial_leak),    32'd0);
      check({tag, "_to"},     32'(bus_a.trial_timeout), 32'd0);
      check({tag, "_sticky"}, 32'(bus_a.leak_sticky),   32'd0);
      check({tag, "_tc"},     32'(bus_a.trial_count),   32'd0);
      check({tag, "_lc"},     32'(bus_a.leak_count),    32'd0);
      check({tag, "_mx"},     32'(bus_a.max_skew),      32'd0);
   endtask

   initial begin
      r_rst   = 1'b0;
      r_start = 1'b1;
      r_d1    = 1'b1;
      r_d2    = 1'b1;
      repeat (2) tick();
      check_all_zero("reset");

      r_start = 1'b0;
      r_d1    = 1'b0;
      r_d2    = 1'b0;
      r_rst   = 1'b1;
      repeat (3) tick();
      check("idle_busy",  32'(bus_a.busy),        32'd0);
      check("idle_valid", 32'(bus_a.trial_valid), 32'd0);

      do_trial(5, 5, 0, 1'b0);   // matched
      do_trial(4, 7, 0, 1'b0);   // skew 3
      do_trial(5, 5, 0, 1'b0);   // matched again, max_skew stays
      do_trial(3, 0, 0, 1'b0);   // timeout on copy two
      check("to_max_skew", 32'(bus_a.max_skew), 32'd3);
      do_trial(5, 5, 2, 1'b0);   // second start while running

      do_trial(6, 6, 0, 1'b1);   // dones left high into idle
      repeat (3) tick();
      check("held_busy", 32'(bus_a.busy), 32'd0);
      do_trial(2, 2, 0, 1'b0);

      // Reset in the middle of a trial.
      r_start = 1'b1;
      tick();
      r_start = 1'b0;
      repeat (2) tick();
      r_rst = 1'b0;
      tick();
      m_tc = 0;
      m_lc = 0;
      m_sticky = 1'b0;
      m_mx = 0;
      check_all_zero("midreset");
      r_rst = 1'b1;
      repeat (3) tick();
      check("post_reset_busy", 32'(bus_a.busy), 32'd0);

      for (int i = 0; i < 5; i++) begin
         do_trial(1, 2, 0, 1'b0);
      end
      check("sat_trial_count", 32'(bus_b.trial_count), 32'd3);
      check("sat_leak_count",  32'(bus_b.leak_count),  32'd3);
      check("wide_trial_count", 32'(bus_a.trial_count), 32'd5);
      check("sb_empty", 32'(q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
